// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: timing presets, bus widths, colour types.
// Optional border overlay is compiled in with VGA_FB_READER_BORDER_EN.
package vga_pkg;

    localparam int unsigned VGA_MAX_H_WIDTH = 11;
    localparam int unsigned VGA_MAX_V_WIDTH = 11;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int unsigned VGA800_H_ACTIVE = 800;
    localparam int unsigned VGA800_H_FP     = 40;
    localparam int unsigned VGA800_H_SYNC   = 128;
    localparam int unsigned VGA800_H_BP     = 88;
    localparam int unsigned VGA800_V_ACTIVE = 600;
    localparam int unsigned VGA800_V_FP     = 1;
    localparam int unsigned VGA800_V_SYNC   = 4;
    localparam int unsigned VGA800_V_BP     = 23;

    // 1280x1024 @ 60 Hz, 108 MHz pixel clock
    localparam int unsigned VGA1280_H_ACTIVE = 1280;
    localparam int unsigned VGA1280_H_FP     = 48;
    localparam int unsigned VGA1280_H_SYNC   = 112;
    localparam int unsigned VGA1280_H_BP     = 248;
    localparam int unsigned VGA1280_V_ACTIVE = 1024;
    localparam int unsigned VGA1280_V_FP     = 1;
    localparam int unsigned VGA1280_V_SYNC   = 3;
    localparam int unsigned VGA1280_V_BP     = 38;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t PAL_DEFAULT_0 = 12'h000;
    localparam rgb12_t PAL_DEFAULT_1 = 12'hFFF;
    localparam rgb12_t PAL_DEFAULT_2 = 12'hF00;
    localparam rgb12_t PAL_DEFAULT_3 = 12'h0F0;
    localparam rgb12_t BORDER_RGB    = 12'hFFF;

    // Per-pixel control bits that travel alongside the memory read latency
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
        logic en;
`ifdef VGA_FB_READER_BORDER_EN
        logic border;
`endif
    } vga_pipe_t;

endpackage

// File: rtl/vga_fb_reader_if.sv
// Frame memory read port between the scan-out reader (master) and memory (slave).
interface vga_fb_reader_if;
    import vga_pkg::*;

    logic                       rd_en;
    logic [VGA_MAX_H_WIDTH-1:0] rd_addr_x;
    logic [VGA_MAX_V_WIDTH-1:0] rd_addr_y;
    logic [1:0]                 rd_data;

    modport master (output rd_en, rd_addr_x, rd_addr_y, input rd_data);
    modport slave  (input rd_en, rd_addr_x, rd_addr_y, output rd_data);

endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters and registered stage-0 decode (active, syncs, first pixel, read address).
// Border flag output exists only with VGA_FB_READER_BORDER_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA800_H_ACTIVE,
    parameter int unsigned H_FP     = VGA800_H_FP,
    parameter int unsigned H_SYNC   = VGA800_H_SYNC,
    parameter int unsigned H_BP     = VGA800_H_BP,
    parameter int unsigned V_ACTIVE = VGA800_V_ACTIVE,
    parameter int unsigned V_FP     = VGA800_V_FP,
    parameter int unsigned V_SYNC   = VGA800_V_SYNC,
    parameter int unsigned V_BP     = VGA800_V_BP
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       enable_i,
    output logic                       active_o,
    output logic                       hs_o,
    output logic                       vs_o,
    output logic                       first_o,
    output logic                       en_frame_o,
`ifdef VGA_FB_READER_BORDER_EN
    output logic                       border_o,
`endif
    output logic [VGA_MAX_H_WIDTH-1:0] addr_x_o,
    output logic [VGA_MAX_V_WIDTH-1:0] addr_y_o
);

    localparam int unsigned HW = VGA_MAX_H_WIDTH;
    localparam int unsigned VW = VGA_MAX_V_WIDTH;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          act_c;
    logic          hs_c;
    logic          vs_c;
    logic          origin_c;
    logic          en_frame;

    always_comb begin
        act_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_c     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        origin_c = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            active_o <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
            first_o  <= 1'b0;
            addr_x_o <= '0;
            addr_y_o <= '0;
            en_frame <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            active_o <= act_c;
            hs_o     <= hs_c;
            vs_o     <= vs_c;
            first_o  <= origin_c;
            addr_x_o <= act_c ? h_cnt : '0;
            addr_y_o <= act_c ? v_cnt : '0;
            // Loaded on the same edge that registers pixel (0,0), so it pairs with that frame
            if (origin_c) begin
                en_frame <= enable_i;
            end
        end
    end

    assign en_frame_o = en_frame;

`ifdef VGA_FB_READER_BORDER_EN
    localparam logic [HW-1:0] H_EDGE = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_EDGE = VW'(V_ACTIVE - 1);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            border_o <= 1'b0;
        end else begin
            border_o <= act_c && ((h_cnt == '0) || (h_cnt == H_EDGE) ||
                                  (v_cnt == '0) || (v_cnt == V_EDGE));
        end
    end
`endif

endmodule

// File: rtl/vga_fb_reader.sv
// VGA scan-out: raster timing, frame memory reads, latency alignment, palette lookup.
// Define VGA_FB_READER_BORDER_EN to overlay a white one-pixel border on enabled frames.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA800_H_ACTIVE,
    parameter int unsigned H_FP       = VGA800_H_FP,
    parameter int unsigned H_SYNC     = VGA800_H_SYNC,
    parameter int unsigned H_BP       = VGA800_H_BP,
    parameter int unsigned V_ACTIVE   = VGA800_V_ACTIVE,
    parameter int unsigned V_FP       = VGA800_V_FP,
    parameter int unsigned V_SYNC     = VGA800_V_SYNC,
    parameter int unsigned V_BP       = VGA800_V_BP,
    parameter logic        SYNC_POL   = 1'b1,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               enable_i,
    vga_fb_reader_if.master    fb,
    input  logic               pal_we_i,
    input  logic [1:0]         pal_idx_i,
    input  rgb12_t             pal_data_i,
    output logic               VGA_HS_o,
    output logic               VGA_VS_o,
    output rgb12_t             RGB_o,
    output logic               frame_start_o
);

    vga_pipe_t s0;
    vga_pipe_t dly [RD_LATENCY];
    vga_pipe_t tail;
    rgb12_t    pal [4];
    rgb12_t    rgb_n;

    logic s0_active;
    logic s0_hs;
    logic s0_vs;
    logic s0_first;
    logic s0_en;
`ifdef VGA_FB_READER_BORDER_EN
    logic s0_border;
`endif

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .enable_i   (enable_i),
        .active_o   (s0_active),
        .hs_o       (s0_hs),
        .vs_o       (s0_vs),
        .first_o    (s0_first),
        .en_frame_o (s0_en),
`ifdef VGA_FB_READER_BORDER_EN
        .border_o   (s0_border),
`endif
        .addr_x_o   (fb.rd_addr_x),
        .addr_y_o   (fb.rd_addr_y)
    );

    assign fb.rd_en = s0_active;

    always_comb begin
        s0        = '0;
        s0.active = s0_active;
        s0.hs     = s0_hs;
        s0.vs     = s0_vs;
        s0.first  = s0_first;
        s0.en     = s0_en;
`ifdef VGA_FB_READER_BORDER_EN
        s0.border = s0_border;
`endif
    end

    // Control bits wait RD_LATENCY clocks so they arrive with rd_data
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= s0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign tail = dly[RD_LATENCY-1];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pal[0] <= PAL_DEFAULT_0;
            pal[1] <= PAL_DEFAULT_1;
            pal[2] <= PAL_DEFAULT_2;
            pal[3] <= PAL_DEFAULT_3;
        end else if (pal_we_i) begin
            pal[pal_idx_i] <= pal_data_i;
        end
    end

    always_comb begin
        rgb_n = '0;
        if (tail.active && tail.en) begin
            rgb_n = pal[fb.rd_data];
`ifdef VGA_FB_READER_BORDER_EN
            if (tail.border) begin
                rgb_n = BORDER_RGB;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            RGB_o         <= '0;
            VGA_HS_o      <= ~SYNC_POL;
            VGA_VS_o      <= ~SYNC_POL;
            frame_start_o <= 1'b0;
        end else begin
            RGB_o         <= rgb_n;
            VGA_HS_o      <= tail.hs ? SYNC_POL : ~SYNC_POL;
            VGA_VS_o      <= tail.vs ? SYNC_POL : ~SYNC_POL;
            frame_start_o <= tail.first;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader on a shrunken 8x4 raster (16x8 total, 128 clks/frame).
module tb_vga_fb_reader;
    import vga_pkg::*;

    localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 3;
    localparam int unsigned VA = 4, VF = 1, VSW = 2, VB = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_idx = 2'd0;
    logic [11:0] pal_data = 12'h000;

    logic        hs_m, vs_m, fs_m;
    logic [11:0] rgb_m;
    logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
    logic [11:0] rgb_a, rgb_b;

    int nerr = 0;
    int nchk = 0;
    int n = 0;

    always #5 clk = ~clk;

    vga_fb_reader_if fb_m ();
    vga_fb_reader_if fb_a ();
    vga_fb_reader_if fb_b ();

    // main memory returns idx = x[1:0], two clocks after the read
    logic [1:0] mem_m1, mem_m2;
    always @(posedge clk) begin
        mem_m1 <= fb_m.rd_addr_x[1:0];
        mem_m2 <= mem_m1;
    end
    assign fb_m.rd_data = mem_m2;

    // sweep memories return idx 1 only for reads that were actually issued
    logic       mem_a;
    logic [3:0] mem_b;
    always @(posedge clk) begin
        mem_a <= fb_a.rd_en;
        mem_b <= {mem_b[2:0], fb_b.rd_en};
    end
    assign fb_a.rd_data = {1'b0, mem_a};
    assign fb_b.rd_data = {1'b0, mem_b[3]};

    vga_fb_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1'b1), .RD_LATENCY(2)
    ) dut_m (
        .clk_i(clk), .arst_i(rst), .enable_i(enable), .fb(fb_m),
        .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_data_i(pal_data),
        .VGA_HS_o(hs_m), .VGA_VS_o(vs_m), .RGB_o(rgb_m), .frame_start_o(fs_m)
    );

    vga_fb_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1'b1), .RD_LATENCY(1)
    ) dut_a (
        .clk_i(clk), .arst_i(rst), .enable_i(1'b1), .fb(fb_a),
        .pal_we_i(1'b0), .pal_idx_i(2'd0), .pal_data_i(12'h000),
        .VGA_HS_o(hs_a), .VGA_VS_o(vs_a), .RGB_o(rgb_a), .frame_start_o(fs_a)
    );

    vga_fb_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1'b1), .RD_LATENCY(4)
    ) dut_b (
        .clk_i(clk), .arst_i(rst), .enable_i(1'b1), .fb(fb_b),
        .pal_we_i(1'b0), .pal_idx_i(2'd0), .pal_data_i(12'h000),
        .VGA_HS_o(hs_b), .VGA_VS_o(vs_b), .RGB_o(rgb_b), .frame_start_o(fs_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at n=%0d: got %0h, expected %0h", nm, n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic go(input int t);
        while (n < t) tick();
    endtask

    function automatic logic [11:0] pal_def(input int i);
        case (i & 3)
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return 12'hF00;
            default: return 12'h0F0;
        endcase
    endfunction

    function automatic logic [11:0] bfix(input logic [11:0] v, input int x, input int y);
`ifdef VGA_FB_READER_BORDER_EN
        if (x >= 0 && (x == 0 || x == HA - 1 || y == 0 || y == VA - 1)) return 12'hFFF;
`endif
        return v;
    endfunction

    // Latency sweep monitor: each visible run is HA white pixels and HS rises HA+HF clks after it starts
    logic [11:0] sw_rgb [2];
    logic        sw_hs [2];
    logic        prev_hs [2];
    int          run [2];
    int          rise_t [2];
    int          bad [2];
    int          lines [2];
    int          tcyc = 0;
    assign sw_rgb[0] = rgb_a;
    assign sw_rgb[1] = rgb_b;
    assign sw_hs[0]  = hs_a;
    assign sw_hs[1]  = hs_b;

    always @(negedge clk) begin
        tcyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                prev_hs[k] = 1'b0;
                run[k]     = 0;
                rise_t[k]  = -1;
                bad[k]     = 0;
            end else begin
                if (sw_rgb[k] != 12'h000 && sw_rgb[k] != 12'hFFF) bad[k] = 1;
                if (sw_rgb[k] == 12'hFFF) begin
                    if (run[k] == 0) rise_t[k] = tcyc;
                    run[k]++;
                end
                if (sw_hs[k] && !prev_hs[k]) begin
                    chk($sformatf("sweep%0d_bad_rgb", k), bad[k], 0);
                    if (run[k] != 0) begin
                        lines[k]++;
                        chk($sformatf("sweep%0d_run_len", k), run[k], HA);
                        chk($sformatf("sweep%0d_hs_gap", k), tcyc - rise_t[k], HA + HF);
                    end
                    run[k]    = 0;
                    rise_t[k] = -1;
                    bad[k]    = 0;
                end
                prev_hs[k] = sw_hs[k];
            end
        end
    end

    typedef struct {
        int          n;
        logic        rd_en;
        int          ax;
        int          ay;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        int          px;
        int          py;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at n=%0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        lines[0] = 0;
        lines[1] = 0;
        // n = clocks since release; rd outputs show raster c=n-1, pins show c=n-4
        tbl.push_back('{  1, 1'b1, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{  4, 1'b1, 3, 0, 12'h000, 1'b0, 1'b0, 1'b1,  0,  0});
        tbl.push_back('{  5, 1'b1, 4, 0, 12'hFFF, 1'b0, 1'b0, 1'b0,  1,  0});
        tbl.push_back('{  6, 1'b1, 5, 0, 12'hF00, 1'b0, 1'b0, 1'b0,  2,  0});
        tbl.push_back('{  7, 1'b1, 6, 0, 12'h0F0, 1'b0, 1'b0, 1'b0,  3,  0});
        tbl.push_back('{  8, 1'b1, 7, 0, 12'h000, 1'b0, 1'b0, 1'b0,  4,  0});
        tbl.push_back('{  9, 1'b0, 0, 0, 12'hFFF, 1'b0, 1'b0, 1'b0,  5,  0});
        tbl.push_back('{ 11, 1'b0, 0, 0, 12'h0F0, 1'b0, 1'b0, 1'b0,  7,  0});
        tbl.push_back('{ 12, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 13, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 14, 1'b0, 0, 0, 12'h000, 1'b1, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 16, 1'b0, 0, 0, 12'h000, 1'b1, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 17, 1'b1, 0, 1, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 20, 1'b1, 3, 1, 12'h000, 1'b0, 1'b0, 1'b0,  0,  1});
        tbl.push_back('{ 21, 1'b1, 4, 1, 12'hFFF, 1'b0, 1'b0, 1'b0,  1,  1});
        tbl.push_back('{ 56, 1'b1, 7, 3, 12'h000, 1'b0, 1'b0, 1'b0,  4,  3});
        tbl.push_back('{ 57, 1'b0, 0, 0, 12'hFFF, 1'b0, 1'b0, 1'b0,  5,  3});
        tbl.push_back('{ 59, 1'b0, 0, 0, 12'h0F0, 1'b0, 1'b0, 1'b0,  7,  3});
        tbl.push_back('{ 60, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 65, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 83, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{ 84, 1'b0, 0, 0, 12'h000, 1'b0, 1'b1, 1'b0, -1, -1});
        tbl.push_back('{115, 1'b0, 0, 0, 12'h000, 1'b0, 1'b1, 1'b0, -1, -1});
        tbl.push_back('{116, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, -1, -1});
        tbl.push_back('{132, 1'b1, 3, 0, 12'h000, 1'b0, 1'b0, 1'b1,  0,  0});
        tbl.push_back('{133, 1'b1, 4, 0, 12'hFFF, 1'b0, 1'b0, 1'b0,  1,  0});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", int'(fb_m.rd_en), 0);
        chk("rst_rgb", int'(rgb_m), 0);
        chk("rst_hs", int'(hs_m), 0);
        chk("rst_vs", int'(vs_m), 0);
        chk("rst_fs", int'(fs_m), 0);
        rst = 1'b0;
        n = 0;

        foreach (tbl[i]) begin
            go(tbl[i].n);
            chk("tbl_rd_en", int'(fb_m.rd_en), int'(tbl[i].rd_en));
            chk("tbl_addr_x", int'(fb_m.rd_addr_x), tbl[i].ax);
            chk("tbl_addr_y", int'(fb_m.rd_addr_y), tbl[i].ay);
            chk("tbl_rgb", int'(rgb_m), int'(bfix(tbl[i].rgb, tbl[i].px, tbl[i].py)));
            chk("tbl_hs", int'(hs_m), int'(tbl[i].hs));
            chk("tbl_vs", int'(vs_m), int'(tbl[i].vs));
            chk("tbl_frame_start", int'(fs_m), int'(tbl[i].fs));
        end

        // palette write lands on the same edge as pixel (1,1)'s lookup: old value there
        go(148);
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 12'h0AB;
        tick();
        pal_we = 1'b0;
        chk("pal_same_edge_old", int'(rgb_m), 12'hFFF);
        go(150);
        chk("pal_other_idx", int'(rgb_m), 12'hF00);
        go(153);
        chk("pal_new_value", int'(rgb_m), 12'h0AB);
        go(160);
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 12'hFFF;
        tick();
        pal_we = 1'b0;
        go(165);
        chk("pal_restored", int'(rgb_m), 12'hFFF);

        // enable drop mid-frame 3 only blanks frame 4; restore shows at frame 5
        go(290);
        enable = 1'b0;
        go(294);
        chk("en_cur_frame_a", int'(rgb_m), int'(bfix(12'hF00, 2, 2)));
        go(309);
        chk("en_cur_frame_b", int'(rgb_m), int'(bfix(12'hFFF, 1, 3)));
        go(398);
        chk("en_off_hs", int'(hs_m), 1);
        go(405);
        chk("en_off_black", int'(rgb_m), 0);
        go(410);
        enable = 1'b1;
        go(421);
        chk("en_still_black", int'(rgb_m), 0);
        go(534);
        chk("en_restored", int'(rgb_m), int'(bfix(12'hF00, 2, 1)));

        // async reset mid-line at h=4
        go(549);
        chk("pre_rst_rgb", int'(rgb_m), int'(bfix(12'hFFF, 1, 2)));
        chk("pre_rst_rd_en", int'(fb_m.rd_en), 1);
        rst = 1'b1;
        #1;
        chk("midrst_rgb", int'(rgb_m), 0);
        chk("midrst_rd_en", int'(fb_m.rd_en), 0);
        chk("midrst_hs", int'(hs_m), 0);
        chk("midrst_vs", int'(vs_m), 0);
        chk("midrst_addr_x", int'(fb_m.rd_addr_x), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_rd_en", int'(fb_m.rd_en), 0);
            chk("hold_rgb", int'(rgb_m), 0);
        end
        rst = 1'b0;
        n = 0;
        tick();
        chk("restart_rd_en", int'(fb_m.rd_en), 1);
        chk("restart_addr_x", int'(fb_m.rd_addr_x), 0);
        chk("restart_addr_y", int'(fb_m.rd_addr_y), 0);
        tick();
        chk("restart_addr_x1", int'(fb_m.rd_addr_x), 1);
        for (int x = 0; x < int'(HA); x++) begin
            go(4 + x);
            chk("row0_rgb", int'(rgb_m), int'(bfix(pal_def(x), x, 0)));
            chk("row0_fs", int'(fs_m), (x == 0) ? 1 : 0);
        end
        go(140);
        chk("sweep0_lines_seen", (lines[0] >= 16) ? 1 : 0, 1);
        chk("sweep1_lines_seen", (lines[1] >= 16) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Scan-out side of the VGA framebuffer: the pixel writer fills frame memory, and this block reads it back.
- Generates H/V raster timing and issues one read per active pixel to frame memory.
- Absorbs fixed memory read latency and maps the 2-bit colour index through a programmable 4-entry palette to 12-bit RGB.
- Sync outputs are pipeline-aligned with RGB; it drives the VGA connector in the pixel clock domain.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, horizontal sync width
H_BP, 88, horizontal back porch
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width
V_BP, 23, vertical back porch
SYNC_POL, 1'b1, active level of HS/VS
RD_LATENCY, 2, clocks from rd_en_o to valid rd_data_i; legal range 1..4

Ports:
clk_i  in  1  pixel clock
arst_i  in  1  asynchronous reset, active-high
enable_i  in  1  1 = show framebuffer, 0 = black; sampled at frame start
rd_en_o  out  1  frame memory read strobe
rd_addr_x_o  out  11  read column
rd_addr_y_o  out  11  read row
rd_data_i  in  2  colour index, valid RD_LATENCY clocks after rd_en_o
pal_we_i  in  1  palette write strobe
pal_idx_i  in  2  palette entry to write
pal_data_i  in  12  palette RGB value
VGA_HS_o  out  1  horizontal sync
VGA_VS_o  out  1  vertical sync
RGB_o  out  12  pixel colour, {R[3:0],G[3:0],B[3:0]}
frame_start_o  out  1  1-clock pulse coincident with pixel (0,0) on RGB_o

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (1056 by default).
  - v_cnt runs 0..V_TOTAL-1 (628 by default) and advances only when h_cnt wraps.
  - Both wrap to 0.
- Stage 0 (counter registers):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - rd_en_o = active.
  - rd_addr_x_o/rd_addr_y_o = h_cnt/v_cnt when active, else 0.
  - All three are driven directly from registers, with no combinational path from inputs.
- Sync decode at stage 0:
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Delay line: active, hs, vs and first-pixel flag go through an RD_LATENCY-deep shift register, so they line up with rd_data_i.
- Output stage (one register):
  - RGB_o = (active_d && en_frame) ? palette[rd_data_i] : 12'h000.
  - VGA_HS_o = hs_d ? SYNC_POL : ~SYNC_POL (VGA_VS_o likewise).
  - frame_start_o = first_d.
- Latency from counter state to pins is RD_LATENCY+1 clocks. HS, VS and RGB stay mutually aligned for every RD_LATENCY.
- en_frame:
  - Loaded from enable_i when h_cnt==0 && v_cnt==0.
  - Held for the whole frame, so a mid-frame toggle never tears.
  - Carried with the pipeline, so it applies to the same frame's pixels.
- Palette:
  - 4x12 register file.
  - Write takes effect on the clock after pal_we_i.
  - A pixel whose output-stage lookup happens on the same edge as the write sees the old value.
  - Writes are allowed at any time.
  - Reset values: idx0=12'h000, 1=12'hFFF, 2=12'hF00, 3=12'h0F0.
- Reset (async assert, sync-released flops):
  - h_cnt=v_cnt=0, pipeline cleared, en_frame=0, palette set to defaults.
  - RGB_o=0, HS/VS=~SYNC_POL, frame_start_o=0, rd_en_o=0.
  - rd_en_o is 0 during reset; after release the first rd_en_o goes high on the first clock.
- Reset mid-line: outputs return to reset values immediately, and the raster restarts at (0,0) after release.
- Boundaries:
  - The last active pixel is (H_ACTIVE-1, V_ACTIVE-1).
  - rd_en_o is low for h_cnt>=H_ACTIVE and on all vertical blanking lines.

Optional Feature:
- VGA_FB_READER_BORDER_EN defined:
  - Active pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 output 12'hFFF, overriding the palette, whenever en_frame=1.
  - The border flag is pipelined alongside active.
- Undefined: no border logic; all active pixels use the palette.

Decomposition:
- vga_pkg:
  - Default timing constants for 800x600 and 1280x1024.
  - VGA_MAX_H_WIDTH/VGA_MAX_V_WIDTH.
  - The rgb12_t typedef and the default palette constants.
- Sub-module vga_timing_gen: counters, active/hs/vs/first-pixel decode.
- vga_fb_reader instantiates vga_timing_gen and owns the delay line, palette and output stage.

Test Plan:
- Reset release, free run: HS period 1056 clks, high 128 clks starting 840 clks after line start; VS high for 4 lines (4224 clks); frame is 663168 clks.
- Model memory returns idx = x[1:0] after 2 clks, enable_i=1: RGB_o sequence is 000,FFF,F00,0F0 repeating; the first pixel appears 3 clks after the first rd_en_o; frame_start_o is coincident with it.
- Sweep RD_LATENCY=1 and 4: HS rising edge stays exactly 840 clks after the first visible pixel of that line; no RGB is nonzero during blanking.
- Write palette idx1=12'h0AB mid-frame: pixels with idx1 looked up at or after the clock following pal_we_i show 0AB; earlier pixels show FFF.
- Deassert enable_i at v=300: the current frame completes normally; the next frame is all 000 with sync intact; reasserting it restores the image at the following frame.
- Assert arst_i mid-line at h=400: RGB_o=0 and HS/VS=~SYNC_POL within the same clock; after release rd_addr restarts at (0,0). With BORDER_EN: row 0 is all FFF.
